// File: rtl/spatial_audio_pkg.sv
// Shared types and constants for the spatial audio path: default widths,
// coefficient unity and the HRTF engine FSM state encoding.
package spatial_audio_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int COEF_W_DEF = 18;
  localparam int N_TAPS_DEF = 32;
  localparam int ACC_W_DEF  = 48;

  // Coefficients are Q2.(COEF_W-2): unity is 2^(COEF_W-2).
  localparam int COEF_UNITY = 1 << (COEF_W_DEF - 2);

  // Rounding adds half an LSB of the output before the arithmetic shift.
  localparam int RND_SHIFT_DEF = COEF_W_DEF - 2;
  localparam int DRAIN_CYCLES  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/fir_mac_lane.sv
// One ear's multiply-accumulate lane: registered product, wide accumulator,
// and round-half-up / saturate back to the sample width.
module fir_mac_lane #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 48
) (
  input  logic                     clk_audio,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     mac_en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [DATA_W-1:0] y
);

  localparam int PW = DATA_W + COEF_W;
  localparam int SH = COEF_W - 2;
  localparam logic signed [ACC_W-1:0] RND   = {{(ACC_W-COEF_W+2){1'b0}}, 1'b1, {(COEF_W-3){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0]    prod_q;
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shifted;

  // prod_vld_q trails mac_en by one cycle so the accumulator only takes real products.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else if (clr) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= PW'(sample) * PW'(coef);
      prod_vld_q <= mac_en;
      if (prod_vld_q) begin
        acc_q <= acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
      end
    end
  end

  always_comb begin
    rnd     = acc_q + RND;
    shifted = rnd >>> SH;
    y       = shifted[DATA_W-1:0];
    if (shifted > Y_MAX) begin
      y = Y_MAX[DATA_W-1:0];
    end else if (shifted < Y_MIN) begin
      y = Y_MIN[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/hrtf_fir_engine.sv
// Mono downmix followed by two time-multiplexed HRTF FIR filters sharing
// one history buffer; results are held for the I2S transmit side.
module hrtf_fir_engine import spatial_audio_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  localparam int AW    = $clog2(N_TAPS)
) (
  input  logic              clk_audio,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_l,
  input  logic [DATA_W-1:0] in_r,
  input  logic              bypass,
  input  logic              coef_we,
  input  logic              coef_ear,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output state_e            state_dbg
);

  localparam logic signed [COEF_W-1:0] C_UNITY = {2'b01, {(COEF_W-2){1'b0}}};

  state_e state_q, state_d;
  logic [AW-1:0]            wp_q, k_q, rd_idx;
  logic                     drain_q;
  logic signed [DATA_W-1:0] hist_q   [N_TAPS];
  logic signed [COEF_W-1:0] coef_l_q [N_TAPS];
  logic signed [COEF_W-1:0] coef_r_q [N_TAPS];
  logic [DATA_W-1:0]        lat_l_q, lat_r_q;
  logic                     byp_q;
  logic signed [DATA_W:0]   m_wide;
  logic signed [DATA_W-1:0] m, y_l, y_r;
  logic                     lane_clr, mac_en;

  // Handshake: in_valid is a one-cycle pulse; it is accepted only in IDLE
  // (data captured on that edge) and otherwise dropped and flagged as overrun.
  assign m_wide    = {lat_l_q[DATA_W-1], lat_l_q} + {lat_r_q[DATA_W-1], lat_r_q};
  assign m         = m_wide[DATA_W:1];
  assign rd_idx    = wp_q - k_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    lane_clr = 1'b0;
    mac_en   = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE:  if (in_valid) state_d = LOAD;
      LOAD:  begin
        lane_clr = 1'b1;
        state_d  = MAC;
      end
      MAC:   begin
        mac_en = 1'b1;
        if (k_q == AW'(N_TAPS - 1)) state_d = DRAIN;
      end
      DRAIN: if (drain_q) state_d = OUT;
      OUT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      k_q       <= '0;
      drain_q   <= 1'b0;
      lat_l_q   <= '0;
      lat_r_q   <= '0;
      byp_q     <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_q == OUT);
      if (state_q == IDLE && in_valid) begin
        lat_l_q <= in_l;
        lat_r_q <= in_r;
      end
      if (state_q == LOAD) begin
        byp_q <= bypass;
        k_q   <= '0;
      end
      if (state_q == MAC) k_q <= k_q + AW'(1);
      drain_q <= (state_q == DRAIN);
      if (state_q == OUT) begin
        out_l <= byp_q ? lat_l_q : y_l;
        out_r <= byp_q ? lat_r_q : y_r;
        wp_q  <= wp_q + AW'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (in_valid && state_q != IDLE) overrun <= 1'b1;
      else if (overrun_clr)            overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        hist_q[i]   <= '0;
        coef_l_q[i] <= (i == 0) ? C_UNITY : '0;
        coef_r_q[i] <= (i == 0) ? C_UNITY : '0;
      end
    end else begin
      if (state_q == LOAD) hist_q[wp_q] <= m;
      if (coef_we) begin
        if (coef_ear) coef_r_q[coef_addr] <= coef_wdata;
        else          coef_l_q[coef_addr] <= coef_wdata;
      end
    end
  end

  fir_mac_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane_l (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .clr       (lane_clr),
    .mac_en    (mac_en),
    .sample    (hist_q[rd_idx]),
    .coef      (coef_l_q[k_q]),
    .y         (y_l)
  );

  fir_mac_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane_r (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .clr       (lane_clr),
    .mac_en    (mac_en),
    .sample    (hist_q[rd_idx]),
    .coef      (coef_r_q[k_q]),
    .y         (y_r)
  );

endmodule

// File: tb/tb_hrtf_fir_engine.sv
// Directed bench for hrtf_fir_engine: passthrough, impulse, rounding,
// saturation, overrun, history wrap, async reset and bypass.
module tb_hrtf_fir_engine;
  import spatial_audio_pkg::*;

  localparam int LAT = 36;

  logic        clk_audio = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic [23:0] in_l      = '0;
  logic [23:0] in_r      = '0;
  logic        bypass    = 1'b0;
  logic        coef_we   = 1'b0;
  logic        coef_ear  = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [17:0] coef_wdata = '0;
  logic        overrun_clr = 1'b0;
  logic [23:0] out_l, out_r;
  logic        out_valid, busy, overrun;
  state_e      state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];

  hrtf_fir_engine dut (
    .clk_audio   (clk_audio),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_l        (in_l),
    .in_r        (in_r),
    .bypass      (bypass),
    .coef_we     (coef_we),
    .coef_ear    (coef_ear),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .overrun_clr (overrun_clr),
    .out_l       (out_l),
    .out_r       (out_r),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  always #5 clk_audio = ~clk_audio;

  task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_audio);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_audio);
    reset_n = 1'b1;
  endtask

  task automatic write_coef(input logic ear, input int addr, input int val);
    @(negedge clk_audio);
    coef_we    = 1'b1;
    coef_ear   = ear;
    coef_addr  = 5'(addr);
    coef_wdata = 18'(val);
    @(negedge clk_audio);
    coef_we    = 1'b0;
  endtask

  // Launch one frame; optionally re-pulse in_valid (and overrun_clr) at cycle inj.
  task automatic run_frame(input logic [23:0] l, input logic [23:0] r, input int inj,
                           input bit inj_clr, output logic [23:0] gl,
                           output logic [23:0] gr, output int lat);
    lat = 0;
    gl  = '0;
    gr  = '0;
    @(negedge clk_audio);
    in_l = l;
    in_r = r;
    in_valid = 1'b1;
    @(posedge clk_audio);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk_audio);
      in_valid    = (cyc == inj);
      overrun_clr = (cyc == inj) && inj_clr;
      @(posedge clk_audio);
      #1;
      if (out_valid) begin
        lat = cyc;
        gl  = out_l;
        gr  = out_r;
        break;
      end
    end
    @(negedge clk_audio);
    in_valid    = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic frame_chk(input string tag, input logic [23:0] l, input logic [23:0] r,
                           input logic [23:0] el, input logic [23:0] er);
    logic [23:0] gl, gr;
    int lat;
    run_frame(l, r, 0, 1'b0, gl, gr, lat);
    check({tag, "_lat"}, 48'(lat), 48'(LAT));
    check({tag, "_l"}, 48'(gl), 48'(el));
    check({tag, "_r"}, 48'(gr), 48'(er));
  endtask

  task automatic count_valid(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk_audio);
      #1;
      if (out_valid) cnt++;
    end
  endtask

  initial begin
    logic [23:0] gl, gr;
    int lat, cnt;

    do_reset();
    #1;
    check("rst_out_l", 48'(out_l), 48'h0);
    check("rst_out_r", 48'(out_r), 48'h0);
    check("rst_valid", 48'(out_valid), 48'h0);
    check("rst_busy", 48'(busy), 48'h0);
    check("rst_overrun", 48'(overrun), 48'h0);
    check("rst_state", 48'(state_dbg), 48'(IDLE));

    // Default coefficients give mono passthrough
    frame_chk("pass1", 24'h100000, 24'h100000, 24'h100000, 24'h100000);
    frame_chk("pass2", 24'h000003, 24'h000000, 24'h000001, 24'h000001);

    // Impulse: left tap 3 at one half, right stays unity at tap 0
    do_reset();
    write_coef(1'b0, 0, 0);
    write_coef(1'b0, 3, 32768);
    frame_chk("imp1", 24'h200000, 24'h200000, 24'h000000, 24'h200000);
    frame_chk("imp2", 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    frame_chk("imp3", 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    frame_chk("imp4", 24'h000000, 24'h000000, 24'h100000, 24'h000000);

    // Rounding: 3 * 0.5 = 1.5 rounds up to 2
    write_coef(1'b0, 3, 0);
    write_coef(1'b0, 0, 32768);
    frame_chk("round", 24'h000003, 24'h000003, 24'h000002, 24'h000003);

    // Saturation with two near-2.0 taps
    write_coef(1'b0, 0, 131071);
    write_coef(1'b0, 1, 131071);
    run_frame(24'h7FFFFF, 24'h7FFFFF, 0, 1'b0, gl, gr, lat);
    check("satp1_r", 48'(gr), 48'h7FFFFF);
    frame_chk("satp2", 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
    run_frame(24'h800000, 24'h800000, 0, 1'b0, gl, gr, lat);
    check("satn1_r", 48'(gr), 48'h800000);
    frame_chk("satn2", 24'h800000, 24'h800000, 24'h800000, 24'h800000);

    // Overrun: drop while busy, computation unaffected
    do_reset();
    run_frame(24'h000200, 24'h000200, 5, 1'b0, gl, gr, lat);
    check("ovr_lat", 48'(lat), 48'(LAT));
    check("ovr_l", 48'(gl), 48'h000200);
    check("ovr_flag", 48'(overrun), 48'h1);
    count_valid(45, cnt);
    check("ovr_single", 48'(cnt), 48'h0);
    run_frame(24'h000300, 24'h000300, 5, 1'b1, gl, gr, lat);
    check("ovr_setwins", 48'(overrun), 48'h1);
    check("ovr2_l", 48'(gl), 48'h000300);
    @(negedge clk_audio);
    overrun_clr = 1'b1;
    @(posedge clk_audio);
    #1;
    check("ovr_clr", 48'(overrun), 48'h0);
    @(negedge clk_audio);
    overrun_clr = 1'b0;

    // Wrap: left uses only tap 31, so out_l(n) = n-31 once history wraps
    do_reset();
    write_coef(1'b0, 0, 0);
    write_coef(1'b0, 31, 65536);
    for (int n = 1; n <= 40; n++) exp_q.push_back((n >= 32) ? 24'(n - 31) : 24'h0);
    for (int n = 1; n <= 40; n++) begin
      logic [23:0] e;
      run_frame(24'(n), 24'(n), 0, 1'b0, gl, gr, lat);
      e = exp_q.pop_front();
      check($sformatf("wrap%0d_l", n), 48'(gl), 48'(e));
      if (n == 1 || n == 32 || n == 40) begin
        check($sformatf("wrap%0d_lat", n), 48'(lat), 48'(LAT));
        check($sformatf("wrap%0d_r", n), 48'(gr), 48'(n));
      end
    end

    // Async reset mid-MAC
    @(negedge clk_audio);
    in_l = 24'h000500;
    in_r = 24'h000500;
    in_valid = 1'b1;
    @(posedge clk_audio);
    @(negedge clk_audio);
    in_valid = 1'b0;
    repeat (9) @(posedge clk_audio);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_l", 48'(out_l), 48'h0);
    check("arst_out_r", 48'(out_r), 48'h0);
    check("arst_busy", 48'(busy), 48'h0);
    check("arst_valid", 48'(out_valid), 48'h0);
    @(negedge clk_audio);
    @(negedge clk_audio);
    reset_n = 1'b1;
    count_valid(45, cnt);
    check("arst_novalid", 48'(cnt), 48'h0);
    frame_chk("arst_pass", 24'h000100, 24'h000100, 24'h000100, 24'h000100);

    // Bypass ignores the filter
    write_coef(1'b0, 0, 0);
    bypass = 1'b1;
    frame_chk("bypass", 24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA);
    bypass = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
